muldiv_seq: RTL

Iterative integer multiply/divide unit for the bexkat2 execute stage. It is the multi-cycle counterpart to the single-cycle ALU. The ALU computes its result in one registered cycle and has no handshake. This block accepts operands on a start pulse, runs one bit per cycle, and returns a double-width result plus condition codes on a one-cycle done pulse. The pipeline control stalls on `busy_o` and writes back on `done_o`.

---
 rtl/muldiv_seq.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit: one bit per cycle, fixed WIDTH+1 cycle latency,
// double-width result and condition codes presented with a one-cycle done pulse.
module muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             c_out,
  output logic             z_out,
  output logic             n_out,
  output logic             v_out,
  output logic             dz_out
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [1:0]       op;
  logic             sign1, sign2;
  logic [WIDTH-1:0] opnd;    // multiplicand, or divisor magnitude
  logic [WIDTH-1:0] acc_hi;  // product high half, or partial remainder
  logic [WIDTH-1:0] acc_lo;  // multiplier bits, or dividend bits becoming quotient
  logic [WIDTH-1:0] orig1;

  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   diff;
  logic               borrow;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   res_lo, res_hi;
  logic               res_v, res_dz;

  always_comb begin
    abs1 = (op_i[0] && in1[WIDTH-1]) ? -in1 : in1;
    abs2 = (op_i[0] && in2[WIDTH-1]) ? -in2 : in2;

    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, opnd};
    borrow  = diff[WIDTH+1];

    prod     = {acc_hi, acc_lo};
    prod_fix = (sign1 ^ sign2) ? -prod : prod;
    quo_fix  = (sign1 ^ sign2) ? -acc_lo : acc_lo;
    rem_fix  = sign1 ? -acc_hi : acc_hi;

    res_lo = prod_fix[WIDTH-1:0];
    res_hi = prod_fix[2*WIDTH-1:WIDTH];
    res_v  = 1'b0;
    res_dz = 1'b0;
    case (op)
      2'b00: res_v = |res_hi;
      2'b01: res_v = (res_hi != {WIDTH{res_lo[WIDTH-1]}});
      default: begin
        res_dz = (opnd == '0);
        if (res_dz) begin
          // With a zero divisor every trial subtract succeeds; override to the defined result.
          res_lo = '1;
          res_hi = orig1;
        end else begin
          res_lo = quo_fix;
          res_hi = rem_fix;
          res_v  = op[0] && sign2 && (opnd == WIDTH'(1)) && (orig1 == MOST_NEG);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      count  <= '0;
      op     <= '0;
      sign1  <= 1'b0;
      sign2  <= 1'b0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      orig1  <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      out    <= '0;
      out_hi <= '0;
      c_out  <= 1'b0;
      z_out  <= 1'b0;
      n_out  <= 1'b0;
      v_out  <= 1'b0;
      dz_out <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            op     <= op_i;
            sign1  <= op_i[0] & in1[WIDTH-1];
            sign2  <= op_i[0] & in2[WIDTH-1];
            orig1  <= in1;
            acc_hi <= '0;
            if (op_i[1]) begin
              opnd   <= abs2;
              acc_lo <= abs1;
            end else begin
              opnd   <= abs1;
              acc_lo <= abs2;
            end
            count  <= CW'(WIDTH);
            busy_o <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          if (op[1]) begin
            acc_hi <= borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], ~borrow};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
          count <= count - 1'b1;
          if (count == CW'(1)) state <= FIX;
        end
        FIX: begin
          out    <= res_lo;
          out_hi <= res_hi;
          c_out  <= 1'b0;
          z_out  <= (res_lo == '0);
          n_out  <= res_lo[WIDTH-1];
          v_out  <= res_v;
          dz_out <= res_dz;
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
